// File: rtl/pl_scoreboard.sv
// Pipeline hazard scoreboard: tracks post-issue stages, picks forwarding sources per operand and
// flags load-use stalls when the youngest producer is a load whose data is not yet forwardable.
module pl_scoreboard #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 2,
  localparam int unsigned SW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic                 issue_regwrite,
  input  logic                 issue_load,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC-1:0]      src_used,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 stall,
  output logic                 issue_fire,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic [DEPTH-1:0]     stage_valid
);

  // Index k of each vector holds stage k+1 (bit 0 = youngest).
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         regwrite_q, regwrite_d;
  logic [DEPTH-1:0]         load_q, load_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;

  logic [NSRC-1:0][DEPTH-1:0] match;
  logic [NSRC-1:0]            load_hit;

  always_comb begin
    match = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        match[i][k] = src_used[i] & valid_q[k] & regwrite_q[k] & (rd_q[k] != '0) &
                      (rd_q[k] == src_addr[i*AW +: AW]);
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; only that one decides the stall.
  always_comb begin
    fwd_sel  = '0;
    load_hit = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match[i][k]) begin
          fwd_sel[i*SW +: SW] = SW'(k + 1);
          load_hit[i]         = load_q[k] & ((k + 1) < int'(LOAD_LAT));
        end
      end
    end
  end

  always_comb begin
    stall       = |load_hit;
    issue_fire  = issue_valid & ~stall & ~flush & ~hold;
    stage_valid = valid_q;
  end

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    load_d     = load_q;
    rd_d       = rd_q;
    if (!hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k]    = valid_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
        load_d[k]     = load_q[k-1];
        rd_d[k]       = rd_q[k-1];
      end
      // Bubbles carry all-zero fields.
      valid_d[0]    = issue_fire;
      regwrite_d[0] = issue_fire & issue_regwrite;
      load_d[0]     = issue_fire & issue_load;
      rd_d[0]       = issue_fire ? issue_rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      load_q     <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      load_q     <= load_d;
      rd_q       <= rd_d;
    end
  end

endmodule

// File: tb/tb_pl_scoreboard.sv
// Self-checking bench for pl_scoreboard: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a stage-list model.
module tb_pl_scoreboard;
  localparam int DEPTH    = 3;
  localparam int NSRC     = 2;
  localparam int AW       = 5;
  localparam int LOAD_LAT = 2;
  localparam int SW       = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 issue_valid = 1'b0;
  logic [AW-1:0]        issue_rd = '0;
  logic                 issue_regwrite = 1'b0;
  logic                 issue_load = 1'b0;
  logic [NSRC*AW-1:0]   src_addr = '0;
  logic [NSRC-1:0]      src_used = '0;
  logic                 flush = 1'b0;
  logic                 hold = 1'b0;
  logic                 stall;
  logic                 issue_fire;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic [DEPTH-1:0]     stage_valid;

  int tests = 0;
  int fails = 0;

  pl_scoreboard #(.DEPTH(DEPTH), .NSRC(NSRC), .AW(AW), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_load(issue_load), .src_addr(src_addr),
    .src_used(src_used), .flush(flush), .hold(hold), .stall(stall), .issue_fire(issue_fire),
    .fwd_sel(fwd_sel), .stage_valid(stage_valid)
  );

  always #5 clk = ~clk;

  // Model: pipe[0] is stage 1 (youngest).
  typedef struct packed { bit v; bit [AW-1:0] rd; bit rw; bit ld; } ent_t;
  ent_t pipe [DEPTH];

  function automatic int exp_fwd(int i);
    for (int j = 0; j < DEPTH; j++)
      if (src_used[i] && pipe[j].v && pipe[j].rw && pipe[j].rd != 0 &&
          pipe[j].rd == src_addr[i*AW +: AW]) return j + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit s = 0;
    for (int i = 0; i < NSRC; i++) begin
      int k = exp_fwd(i);
      if (k != 0 && pipe[k-1].ld && k < LOAD_LAT) s = 1;
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else if (!hold) begin
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
      pipe[0] <= '{v: issue_valid && !exp_stall() && !flush, rd: issue_rd,
                   rw: issue_regwrite, ld: issue_load};
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [DEPTH-1:0] ev;
    for (int k = 0; k < DEPTH; k++) ev[k] = pipe[k].v;
    chk("model stage_valid", int'(stage_valid), int'(ev));
    for (int i = 0; i < NSRC; i++)
      chk($sformatf("model fwd_sel[%0d]", i), int'(fwd_sel[i*SW +: SW]), exp_fwd(i));
    chk("model stall", int'(stall), int'(exp_stall()));
    chk("model issue_fire", int'(issue_fire),
        int'(issue_valid && !exp_stall() && !flush && !hold));
  endtask

  task automatic step(input bit v, input int rd, input bit rw, input bit ld,
                      input int s0, input int s1, input int used, input bit fl, input bit ho);
    @(negedge clk);
    issue_valid    = v;
    issue_rd       = AW'(rd);
    issue_regwrite = rw;
    issue_load     = ld;
    src_addr       = {AW'(s1), AW'(s0)};
    src_used       = NSRC'(used);
    flush          = fl;
    hold           = ho;
    #1 check_model();
  endtask

  function automatic int fsel(int i);
    return int'(fwd_sel[i*SW +: SW]);
  endfunction

  initial begin
    #2;
    chk("reset stage_valid", int'(stage_valid), 0);
    chk("reset stall", int'(stall), 0);
    chk("reset fwd_sel", int'(fwd_sel), 0);
    @(negedge clk);
    rst = 1'b1;

    // ALU writes x5, consumer forwards from stage 1.
    step(1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 0, 1, 0, 0);
    chk("alu fwd0", fsel(0), 1);
    chk("alu stall", int'(stall), 0);

    // Load x7 then use: one stall cycle, then forward from stage 2.
    step(1, 7, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 7, 0, 1, 0, 0);
    chk("load-use stall", int'(stall), 1);
    chk("load-use fire", int'(issue_fire), 0);
    step(1, 0, 0, 0, 7, 0, 1, 0, 0);
    chk("load-use fwd0", fsel(0), 2);
    chk("load-use stall2", int'(stall), 0);
    chk("load-use fire2", int'(issue_fire), 1);

    // Stage 1 ALU and stage 3 load both write x9: youngest wins.
    step(1, 9, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 9, 2, 0, 0);
    chk("x9 fwd1", fsel(1), 1);
    chk("x9 stall", int'(stall), 0);

    // Flush squashes the ID instruction.
    step(1, 4, 1, 0, 0, 0, 0, 1, 0);
    chk("flush fire", int'(issue_fire), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush stage1", int'(stage_valid[0]), 0);
    chk("flush shifted", int'(stage_valid), 3'b100);

    // Hold with stages {x3, x4, x6}.
    step(1, 6, 1, 0, 0, 0, 0, 0, 0);
    step(1, 4, 1, 0, 0, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 8, 1, 0, 4, 6, 3, 0, 1);
      chk("hold stage_valid", int'(stage_valid), 3'b111);
      chk("hold fwd0", fsel(0), 2);
      chk("hold fwd1", fsel(1), 3);
    end
    step(0, 0, 0, 0, 4, 6, 3, 0, 0);
    step(0, 0, 0, 0, 4, 6, 3, 0, 0);
    chk("release stage_valid", int'(stage_valid), 3'b110);
    chk("release fwd0", fsel(0), 3);
    chk("release fwd1", fsel(1), 0);

    // Asynchronous reset between edges with all stages valid.
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    src_addr = '0;
    src_used = '1;
    #1;
    chk("async rst stage_valid", int'(stage_valid), 0);
    chk("async rst fwd x0", int'(fwd_sel), 0);
    check_model();
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(3, 0) != 0,
           $urandom_range(2, 0) == 0, $urandom_range(7, 0), $urandom_range(7, 0),
           $urandom_range(3, 0), $urandom_range(7, 0) == 0, $urandom_range(4, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
